// File: rtl/regfile_wb_arbiter.sv
// Elpis register-file write-back arbiter.
// Round-robin grant of three producers onto one registered write port.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hold,
  input  logic [2:0]            req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr_0,
  input  logic [ADDR_WIDTH-1:0] req_addr_1,
  input  logic [ADDR_WIDTH-1:0] req_addr_2,
  input  logic [DATA_WIDTH-1:0] req_data_0,
  input  logic [DATA_WIDTH-1:0] req_data_1,
  input  logic [DATA_WIDTH-1:0] req_data_2,
  output logic [2:0]            req_ready,
  output logic                  wrd,
  output logic [ADDR_WIDTH-1:0] addr_d,
  output logic [DATA_WIDTH-1:0] d,
  output logic [1:0]            grant_id
);

  localparam logic [1:0] NONE = 2'd3;

  logic [1:0]            ptr;
  logic [1:0]            sel;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  always_comb begin
    sel = NONE;
    unique case (ptr)
      2'd1: begin
        if (req_valid[1])      sel = 2'd1;
        else if (req_valid[2]) sel = 2'd2;
        else if (req_valid[0]) sel = 2'd0;
      end
      2'd2: begin
        if (req_valid[2])      sel = 2'd2;
        else if (req_valid[0]) sel = 2'd0;
        else if (req_valid[1]) sel = 2'd1;
      end
      default: begin
        if (req_valid[0])      sel = 2'd0;
        else if (req_valid[1]) sel = 2'd1;
        else if (req_valid[2]) sel = 2'd2;
      end
    endcase
    // ready also drops combinationally while reset is held low
    if (hold || !reset) sel = NONE;
  end

  always_comb begin
    req_ready = 3'b000;
    sel_addr  = req_addr_0;
    sel_data  = req_data_0;
    unique case (1'b1)
      (sel == 2'd0): begin
        req_ready = 3'b001;
      end
      (sel == 2'd1): begin
        req_ready = 3'b010;
        sel_addr  = req_addr_1;
        sel_data  = req_data_1;
      end
      (sel == 2'd2): begin
        req_ready = 3'b100;
        sel_addr  = req_addr_2;
        sel_data  = req_data_2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr      <= 2'd0;
      wrd      <= 1'b0;
      addr_d   <= '0;
      d        <= '0;
      grant_id <= NONE;
    end else if (sel != NONE) begin
      ptr      <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
      addr_d   <= sel_addr;
      d        <= sel_data;
      grant_id <= sel;
      // x0 writes are consumed but never issued
      wrd      <= (sel_addr != '0);
    end else begin
      wrd      <= 1'b0;
      grant_id <= NONE;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter.
// Directed scenarios plus random traffic against a round-robin model.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        hold;
  logic [2:0]  req_valid;
  logic [4:0]  ra [3];
  logic [31:0] rd [3];
  logic [4:0]  ra0, ra1, ra2;
  logic [31:0] rd0, rd1, rd2;
  logic [2:0]  req_ready;
  logic        wrd;
  logic [4:0]  addr_d;
  logic [31:0] d;
  logic [1:0]  grant_id;

  assign ra0 = ra[0];
  assign ra1 = ra[1];
  assign ra2 = ra[2];
  assign rd0 = rd[0];
  assign rd1 = rd[1];
  assign rd2 = rd[2];

  regfile_wb_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .hold(hold),
    .req_valid(req_valid),
    .req_addr_0(ra0), .req_addr_1(ra1), .req_addr_2(ra2),
    .req_data_0(rd0), .req_data_1(rd1), .req_data_2(rd2),
    .req_ready(req_ready),
    .wrd(wrd), .addr_d(addr_d), .d(d), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int          m_ptr;
  logic        m_wrd;
  logic [4:0]  m_addr;
  logic [31:0] m_d;
  logic [1:0]  m_gid;

  function automatic int model_grant();
    if (hold || !reset) return 3;
    for (int i = 0; i < 3; i++) begin
      int k;
      k = (m_ptr + i) % 3;
      if (req_valid[k]) return k;
    end
    return 3;
  endfunction

  task automatic model_reset();
    m_ptr  = 0;
    m_wrd  = 1'b0;
    m_addr = '0;
    m_d    = '0;
    m_gid  = 2'd3;
  endtask

  task automatic check_outs(string name);
    n_checks++;
    if (wrd !== m_wrd) begin
      n_fail++;
      $display("FAIL %s wrd got %b want %b", name, wrd, m_wrd);
    end
    n_checks++;
    if (grant_id !== m_gid) begin
      n_fail++;
      $display("FAIL %s grant_id got %0d want %0d", name, grant_id, m_gid);
    end
    n_checks++;
    if (addr_d !== m_addr) begin
      n_fail++;
      $display("FAIL %s addr_d got %0d want %0d", name, addr_d, m_addr);
    end
    n_checks++;
    if (d !== m_d) begin
      n_fail++;
      $display("FAIL %s d got %h want %h", name, d, m_d);
    end
  endtask

  // Entered at posedge+1 with inputs applied; leaves at next posedge+1.
  task automatic step(input string name, output int g);
    logic [2:0] exp_rdy;
    #1;
    g = model_grant();
    exp_rdy = (g == 3) ? 3'b000 : 3'(1 << g);
    n_checks++;
    if (req_ready !== exp_rdy) begin
      n_fail++;
      $display("FAIL %s req_ready got %b want %b", name, req_ready, exp_rdy);
    end
    @(posedge clk);
    if (g != 3) begin
      m_ptr  = (g + 1) % 3;
      m_addr = ra[g];
      m_d    = rd[g];
      m_gid  = 2'(g);
      m_wrd  = (ra[g] != 0);
    end else begin
      m_wrd = 1'b0;
      m_gid = 2'd3;
    end
    #1;
    check_outs(name);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #3 reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    hold = 1'b0;
    req_valid = 3'b111;
    for (int k = 0; k < 3; k++) begin
      ra[k] = 5'(k + 1);
      rd[k] = 32'hA0 + k;
    end
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_outs("reset");
    n_checks++;
    if (req_ready !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ready got %b want 000", req_ready);
    end
    #3 reset = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 3'b001) begin
      n_fail++;
      $display("FAIL reset_first got %b want 001", req_ready);
    end
    req_valid = 3'b000;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    int g;
    req_valid = 3'b010;
    ra[1] = 5'd7;
    rd[1] = 32'hDEADBEEF;
    step("single", g);
    n_checks++;
    if (wrd !== 1'b1 || addr_d !== 5'd7 || d !== 32'hDEADBEEF || grant_id !== 2'd1) begin
      n_fail++;
      $display("FAIL single_direct got %b/%0d/%h/%0d want 1/7/deadbeef/1",
               wrd, addr_d, d, grant_id);
    end
    req_valid = 3'b000;
    step("single_idle", g);
  endtask

  task automatic test_round_robin();
    int g;
    int seq [6] = '{0, 1, 2, 0, 1, 2};
    do_reset();
    req_valid = 3'b111;
    for (int k = 0; k < 3; k++) begin
      ra[k] = 5'(k + 10);
      rd[k] = 32'h100 * (k + 1);
    end
    for (int i = 0; i < 6; i++) begin
      step("rr", g);
      n_checks++;
      if (grant_id !== 2'(seq[i]) || wrd !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_seq[%0d] got id %0d wrd %b want id %0d wrd 1",
                 i, grant_id, wrd, seq[i]);
      end
    end
    req_valid = 3'b000;
    step("rr_idle", g);
  endtask

  task automatic test_pointer();
    int g;
    do_reset();
    req_valid = 3'b100;
    step("ptr_2", g);
    req_valid = 3'b011;
    step("ptr_0", g);
    n_checks++;
    if (grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL ptr_wrap got %0d want 0", grant_id);
    end
    req_valid = 3'b010;
    step("ptr_1", g);
    n_checks++;
    if (grant_id !== 2'd1) begin
      n_fail++;
      $display("FAIL ptr_next got %0d want 1", grant_id);
    end
    req_valid = 3'b000;
    step("ptr_idle", g);
  endtask

  task automatic test_x0();
    int g;
    req_valid = 3'b001;
    ra[0] = 5'd0;
    rd[0] = 32'h1234;
    step("x0", g);
    n_checks++;
    if (wrd !== 1'b0 || grant_id !== 2'd0 || addr_d !== 5'd0 || d !== 32'h1234) begin
      n_fail++;
      $display("FAIL x0_direct got %b/%0d/%0d/%h want 0/0/0/1234",
               wrd, grant_id, addr_d, d);
    end
    req_valid = 3'b000;
    step("x0_idle", g);
  endtask

  task automatic test_hold_async();
    int g;
    for (int k = 0; k < 3; k++) ra[k] = 5'(k + 20);
    req_valid = 3'b111;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) step("hold", g);
    hold = 1'b0;
    step("hold_resume", g);
    n_checks++;
    if (grant_id !== 2'd1) begin
      n_fail++;
      $display("FAIL hold_ptr got %0d want 1", grant_id);
    end
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_outs("async_reset");
    n_checks++;
    if (req_ready !== 3'b000) begin
      n_fail++;
      $display("FAIL async_ready got %b want 000", req_ready);
    end
    #2 reset = 1'b1;
    req_valid = 3'b000;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    int g;
    logic [2:0] pend;
    pend = 3'b000;
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 3; k++) begin
        if (!pend[k] && ($urandom % 2 == 1)) begin
          pend[k] = 1'b1;
          ra[k] = ($urandom % 6 == 0) ? 5'd0 : 5'($urandom);
          rd[k] = $urandom;
        end
      end
      hold = ($urandom % 8 == 0);
      req_valid = pend;
      step("random", g);
      if (g != 3) pend[g] = 1'b0;
    end
    hold = 1'b0;
    req_valid = 3'b000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_pointer();
    test_x0();
    test_hold_async();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
